mb8_arb: RTL and testbench
==========================

MB8_ARB -- requirements
Module: mb8_arb

Interface
REQ-001 Parameter AW, default 17, SHALL set address width (128 KB byte SRAM).
REQ-002 Parameter LOCK_MAX, default 16, SHALL set maximum consecutive granted beats in a locked burst.
REQ-003 Ports SHALL be:
- clk  in  1  system clock; SRAM samples on ~clk.
- rst  in  1  asynchronous, active-low reset.
- req[2:0]  in  3  per-requester access request (0 core, 1 host loader, 2 output drain).
- we[2:0]  in  3  per-requester write enable.
- lock[2:0]  in  3  per-requester burst lock.
- addr0/addr1/addr2  in  AW each  per-requester byte address.
- wdata0/wdata1/wdata2  in  8 each  per-requester write data.
- gnt[2:0]  out  3  one-hot grant; access performed this cycle.
- rvld[2:0]  out  3  one-hot read-data-valid to the requester granted a read in the previous cycle.
- rdata  out  8  read data, shared by all requesters.
- mem_addr  out  AW  SRAM address.
- mem_we  out  1  SRAM write enable.
- mem_wd  out  8  SRAM write data.
- mem_rd  in  8  SRAM read data (valid one clk after address).
- lock_abort  out  1  single-cycle pulse on forced lock release.

Function
REQ-004 gnt SHALL be combinational from req, the round-robin pointer rr and the FSM state; at most one bit SHALL be set.
REQ-005 The granted requester's addr/we/wdata SHALL drive mem_addr/mem_we/mem_wd in the same cycle.
REQ-006 With no grant: mem_we=0, mem_addr holds its last driven value, mem_wd=0.
REQ-007 FSM states: ARB and LOCKED. Owner register own[1:0]. Beat counter bcnt, width clog2(LOCK_MAX+1).
REQ-008 In ARB, the grant SHALL go to the first asserted req searching from rr, rr+1, rr+2 (mod 3).
REQ-009 On any grant in ARB, rr SHALL become (granted index + 1) mod 3 at the next edge.
REQ-010 In ARB, a grant with lock set SHALL move to LOCKED with own=index and bcnt=1.
REQ-011 In LOCKED, only own SHALL be granted, and only while req[own]=1; all other requests wait.
REQ-012 In LOCKED, each granted beat SHALL increment bcnt.
REQ-013 LOCKED -> ARB when lock[own]=0 or req[own]=0; the current cycle is arbitrated as in ARB.
REQ-014 LOCKED -> ARB when bcnt=LOCK_MAX and req[own]=1; that cycle grants per REQ-008 with own excluded, and lock_abort SHALL pulse for one cycle.
REQ-015 A read grant (gnt[i]=1, we[i]=0) in cycle N SHALL produce rvld[i]=1 and rdata=mem_rd in cycle N+1.
REQ-016 Write grants SHALL produce no rvld.
REQ-017 Back-to-back reads, including by different requesters, SHALL each return data one cycle later, with no bubble.
REQ-018 A requester SHALL hold req, addr, we and wdata stable until it sees gnt; the arbiter registers none of them.
REQ-019 Simultaneous equal requests SHALL resolve strictly per rr; no requester waits more than 2 grants while unlocked.
REQ-020 Deasserting req while not granted SHALL withdraw the request with no side effect.

Reset
REQ-021 While rst=0: state=ARB, rr=0, own=0, bcnt=0, gnt=0, rvld=0, rdata=0, mem_we=0, mem_addr=0, lock_abort=0.
REQ-022 Reset asserted mid-burst SHALL drop the lock and any pending rvld immediately, without waiting for a clk edge.
REQ-023 First arbitration after rst rises SHALL start from requester 0.

Verification
REQ-024 Reset, then req=3'b111, all reads, no lock -> gnt sequence 001, 010, 100, 001; each rvld one cycle after its grant, with rdata = preloaded byte.
REQ-025 Requester 1 writes 0x5A to 0x01000, then requester 0 reads 0x01000 next cycle -> rvld[0]=1 with rdata=0x5A one cycle after the read grant.
REQ-026 Requester 2 locks with req held for 20 cycles, LOCK_MAX=16, while req[0]=1 -> 16 consecutive gnt=100; lock_abort pulses with gnt=001 on beat 17; rr=1 afterwards.
REQ-027 Requester 1 locks, drops lock after 3 beats, while req[2]=1 -> gnt=010 x3 then gnt=100 on the cycle lock falls; no lock_abort.
REQ-028 rst driven low between clock edges during a locked read burst -> gnt, rvld and mem_we go 0 immediately; after release the first grant follows rr=0.
REQ-029 Bench SHALL check in every cycle: gnt is one-hot-or-zero, rvld matches the previous cycle's read grant, and mem_we=0 whenever gnt=0.

Source files
------------

// File: rtl/mb8_arb_if.sv
// Requester-side and SRAM-side signal bundle for the three-way byte SRAM arbiter.
// The master modport is the requesters plus the SRAM; the slave modport is the arbiter.
interface mb8_arb_if #(
  parameter int AW = 17
);
  logic [2:0]    req;
  logic [2:0]    we;
  logic [2:0]    lock;
  logic [AW-1:0] addr0, addr1, addr2;
  logic [7:0]    wdata0, wdata1, wdata2;
  logic [2:0]    gnt;
  logic [2:0]    rvld;
  logic [7:0]    rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [7:0]    mem_wd;
  logic [7:0]    mem_rd;
  logic          lock_abort;

  modport master (
    output req, we, lock, addr0, addr1, addr2, wdata0, wdata1, wdata2, mem_rd,
    input  gnt, rvld, rdata, mem_addr, mem_we, mem_wd, lock_abort
  );

  modport slave (
    input  req, we, lock, addr0, addr1, addr2, wdata0, wdata1, wdata2, mem_rd,
    output gnt, rvld, rdata, mem_addr, mem_we, mem_wd, lock_abort
  );
endinterface

// File: rtl/mb8_arb.sv
// Round-robin arbiter sharing one byte SRAM between core, host loader and output drain,
// with bounded locked bursts and a one-cycle read-data return path.
module mb8_arb #(
  parameter int AW       = 17,
  parameter int LOCK_MAX = 16
) (
  input  logic     clk,
  input  logic     rst,
  mb8_arb_if.slave bus
);
  localparam int BW = $clog2(LOCK_MAX + 1);

  typedef enum logic {ARB, LOCKED} state_t;

  state_t        state;
  logic [1:0]    rr;
  logic [1:0]    own;
  logic [BW-1:0] bcnt;
  logic [AW-1:0] addr_q;
  logic [2:0]    rvld_q;

  logic          held, expire, keep;
  logic          pick_vld, grant_vld;
  logic [1:0]    pick, grant_idx, idx;
  logic [2:0]    cand, gnt_c;
  logic          we_c;
  logic [AW-1:0] addr_c;
  logic [7:0]    wdata_c;

  function automatic logic [1:0] add_mod3(input logic [1:0] a, input logic [1:0] b);
    logic [2:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
  endfunction

  always_comb begin
    // NOTE: every signal is given a default before any branch so no path infers a latch.
    held      = (state == LOCKED) && bus.req[own];
    expire    = held && (bcnt == BW'(LOCK_MAX));
    keep      = held && bus.lock[own] && !expire;
    cand      = bus.req;
    pick_vld  = 1'b0;
    pick      = rr;
    idx       = rr;
    we_c      = 1'b0;
    addr_c    = addr_q;
    wdata_c   = 8'h00;
    if (expire) cand[own] = 1'b0;
    // Walk the search order backwards so the earliest candidate after rr wins.
    for (int k = 2; k >= 0; k--) begin
      idx = add_mod3(rr, 2'(k));
      if (cand[idx]) begin
        pick_vld = 1'b1;
        pick     = idx;
      end
    end
    grant_idx = keep ? own : pick;
    // The FSM resets to ARB, which would still grant; gating with rst silences the bus at once.
    grant_vld = rst && (keep || pick_vld);
    gnt_c     = grant_vld ? (3'b001 << grant_idx) : 3'b000;
    if (grant_vld) begin
      we_c = bus.we[grant_idx];
      case (grant_idx)
        2'd1:    begin addr_c = bus.addr1; wdata_c = bus.wdata1; end
        2'd2:    begin addr_c = bus.addr2; wdata_c = bus.wdata2; end
        default: begin addr_c = bus.addr0; wdata_c = bus.wdata0; end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= ARB;
      rr     <= 2'd0;
      own    <= 2'd0;
      bcnt   <= '0;
      addr_q <= '0;
      rvld_q <= 3'b000;
    end else begin
      rvld_q <= gnt_c & ~bus.we;
      if (grant_vld) addr_q <= addr_c;
      if (keep) begin
        bcnt <= bcnt + BW'(1);
      end else if (pick_vld && bus.lock[pick]) begin
        rr    <= add_mod3(pick, 2'd1);
        state <= LOCKED;
        own   <= pick;
        bcnt  <= BW'(1);
      end else begin
        if (pick_vld) rr <= add_mod3(pick, 2'd1);
        state <= ARB;
        bcnt  <= '0;
      end
    end
  end

  assign bus.gnt        = gnt_c;
  assign bus.mem_we     = we_c;
  assign bus.mem_addr   = addr_c;
  assign bus.mem_wd     = wdata_c;
  assign bus.lock_abort = rst && expire;
  assign bus.rvld       = rvld_q;
  assign bus.rdata      = (|rvld_q) ? bus.mem_rd : 8'h00;
endmodule

// File: tb/tb_mb8_arb.sv
// Bench for mb8_arb: directed scenarios with literal expectations, then randomized traffic,
// all compared every cycle against a behavioural arbiter and SRAM model.
module tb_mb8_arb;
  localparam int AW       = 17;
  localparam int LOCK_MAX = 16;
  localparam int DEPTH    = 1 << AW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mb8_arb_if #(.AW(AW)) bus();

  mb8_arb #(.AW(AW), .LOCK_MAX(LOCK_MAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [7:0] pre(input int a);
    return 8'((a & 255) ^ ((a >> 8) & 255) ^ 8'h3C);
  endfunction

  // SRAM environment: captures address and write on ~clk, presents read data one clk later.
  logic [7:0]    sram [DEPTH];
  logic [AW-1:0] sram_ra;
  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) sram[bus.mem_addr] = bus.mem_wd;
    sram_ra <= bus.mem_addr;
  end
  always @(posedge clk) bus.mem_rd <= sram[sram_ra];

  // Behavioural model of the arbiter, stepped once per cycle.
  logic [7:0]    mdl_mem [DEPTH];
  int            m_rr, m_own, m_beats, m_prev_idx;
  bit            m_locked, m_prev_rd;
  logic [7:0]    m_prev_data;
  logic [AW-1:0] m_last_addr;
  logic [2:0]    seen_gnt;

  function automatic int pick(input logic [2:0] r, input int start, input int excl);
    for (int k = 0; k < 3; k++) begin
      int i = (start + k) % 3;
      if (r[i] && i != excl) return i;
    end
    return -1;
  endfunction

  always @(negedge clk) begin : cmp
    logic [2:0]    r, w, l, exp_gnt, exp_rvld;
    logic [AW-1:0] a [3];
    logic [7:0]    d [3];
    int            g;
    bit            abort, arb;
    if (!rst) begin
      check("rst_gnt", bus.gnt, 3'b000);
      check("rst_rvld", bus.rvld, 3'b000);
      check("rst_rdata", bus.rdata, 8'h00);
      check("rst_mem_we", bus.mem_we, 1'b0);
      check("rst_mem_addr", bus.mem_addr, '0);
      check("rst_lock_abort", bus.lock_abort, 1'b0);
      m_rr = 0; m_own = 0; m_beats = 0; m_locked = 1'b0;
      m_prev_rd = 1'b0; m_prev_idx = 0; m_prev_data = 8'h00; m_last_addr = '0;
    end else begin
      r = bus.req; w = bus.we; l = bus.lock;
      a[0] = bus.addr0;  a[1] = bus.addr1;  a[2] = bus.addr2;
      d[0] = bus.wdata0; d[1] = bus.wdata1; d[2] = bus.wdata2;
      abort = 1'b0; arb = 1'b1;
      if (m_locked && r[m_own] && m_beats == LOCK_MAX) begin
        g = pick(r, m_rr, m_own);
        abort = 1'b1;
      end else if (m_locked && r[m_own] && l[m_own]) begin
        g = m_own;
        m_beats++;
        arb = 1'b0;
      end else begin
        g = pick(r, m_rr, -1);
      end
      if (arb) begin
        m_locked = 1'b0;
        if (g >= 0) begin
          m_rr = (g + 1) % 3;
          if (l[g]) begin m_locked = 1'b1; m_own = g; m_beats = 1; end
        end
      end
      exp_gnt  = (g >= 0) ? 3'(1 << g) : 3'b000;
      exp_rvld = m_prev_rd ? 3'(1 << m_prev_idx) : 3'b000;
      check("gnt", bus.gnt, exp_gnt);
      check("lock_abort", bus.lock_abort, abort);
      check("mem_we", bus.mem_we, (g >= 0) ? w[g] : 1'b0);
      check("mem_addr", bus.mem_addr, (g >= 0) ? a[g] : m_last_addr);
      check("mem_wd", bus.mem_wd, (g >= 0) ? d[g] : 8'h00);
      check("rvld", bus.rvld, exp_rvld);
      check("rdata", bus.rdata, m_prev_rd ? m_prev_data : 8'h00);
      check("gnt_onehot0", ($countones(bus.gnt) <= 1), 1);
      if (bus.gnt == 3'b000) check("idle_we", bus.mem_we, 1'b0);
      m_prev_rd = (g >= 0) && !w[g];
      if (m_prev_rd) begin m_prev_idx = g; m_prev_data = mdl_mem[a[g]]; end
      if (g >= 0 && w[g]) mdl_mem[a[g]] = d[g];
      if (g >= 0) m_last_addr = a[g];
    end
    seen_gnt = bus.gnt;
  end

  task automatic cyc(input string name, input logic [2:0] r, input logic [2:0] w,
                     input logic [2:0] l, input logic [2:0] exp_gnt);
    @(posedge clk); #1;
    bus.req = r; bus.we = w; bus.lock = l;
    @(negedge clk); #1;
    check(name, bus.gnt, exp_gnt);
  endtask

  task automatic drive_port(input int i, input logic r, input logic w,
                            input logic [AW-1:0] a, input logic [7:0] d);
    bus.req[i] = r;
    bus.we[i]  = w;
    case (i)
      0:       begin bus.addr0 = a; bus.wdata0 = d; end
      1:       begin bus.addr1 = a; bus.wdata1 = d; end
      default: begin bus.addr2 = a; bus.wdata2 = d; end
    endcase
  endtask

  initial begin
    bus.req = 3'b000; bus.we = 3'b000; bus.lock = 3'b000;
    bus.addr0 = '0; bus.addr1 = '0; bus.addr2 = '0;
    bus.wdata0 = 8'h00; bus.wdata1 = 8'h00; bus.wdata2 = 8'h00;
    for (int i = 0; i < DEPTH; i++) begin
      sram[i]    = pre(i);
      mdl_mem[i] = pre(i);
    end
    #1 rst = 1'b0;
    bus.req = 3'b111;
    @(negedge clk); #1;
    check("reset_gnt_gated", bus.gnt, 3'b000);
    check("reset_lock_abort", bus.lock_abort, 1'b0);
    bus.req = 3'b000;
    @(posedge clk); #3;
    rst = 1'b1;
    bus.addr0 = AW'('h10); bus.addr1 = AW'('h20); bus.addr2 = AW'('h30);

    // Round-robin over three simultaneous reads.
    cyc("rr_g0", 3'b111, 3'b000, 3'b000, 3'b001);
    cyc("rr_g1", 3'b111, 3'b000, 3'b000, 3'b010);
    check("rr_rvld0", bus.rvld, 3'b001);
    check("rr_rdata0", bus.rdata, 8'h2C);
    cyc("rr_g2", 3'b111, 3'b000, 3'b000, 3'b100);
    check("rr_rvld1", bus.rvld, 3'b010);
    check("rr_rdata1", bus.rdata, 8'h1C);
    cyc("rr_g3", 3'b111, 3'b000, 3'b000, 3'b001);
    check("rr_rvld2", bus.rvld, 3'b100);
    check("rr_rdata2", bus.rdata, 8'h0C);
    cyc("rr_idle", 3'b000, 3'b000, 3'b000, 3'b000);
    check("rr_rvld3", bus.rvld, 3'b001);

    // Write by requester 1, read-back by requester 0 in the next cycle.
    bus.addr1 = AW'('h01000); bus.wdata1 = 8'h5A; bus.addr0 = AW'('h01000);
    cyc("wr_gnt", 3'b010, 3'b010, 3'b000, 3'b010);
    check("wr_mem_we", bus.mem_we, 1'b1);
    check("wr_mem_wd", bus.mem_wd, 8'h5A);
    cyc("rd_gnt", 3'b001, 3'b000, 3'b000, 3'b001);
    check("wr_no_rvld", bus.rvld, 3'b000);
    cyc("rd_ret", 3'b000, 3'b000, 3'b000, 3'b000);
    check("rd_rvld", bus.rvld, 3'b001);
    check("rd_rdata", bus.rdata, 8'h5A);
    check("idle_addr_held", bus.mem_addr, AW'('h01000));

    // Requester 1 locks for three beats, then drops lock while requester 2 waits.
    cyc("lk1_b1", 3'b110, 3'b000, 3'b010, 3'b010);
    cyc("lk1_b2", 3'b110, 3'b000, 3'b010, 3'b010);
    cyc("lk1_b3", 3'b110, 3'b000, 3'b010, 3'b010);
    cyc("lk1_drop", 3'b110, 3'b000, 3'b000, 3'b100);
    check("lk1_no_abort", bus.lock_abort, 1'b0);
    cyc("lk1_idle", 3'b000, 3'b000, 3'b000, 3'b000);

    // Requester 2 holds a locked burst past LOCK_MAX while requester 0 waits.
    cyc("lk2_b1", 3'b100, 3'b000, 3'b100, 3'b100);
    for (int b = 2; b <= LOCK_MAX; b++) begin
      cyc("lk2_beat", 3'b101, 3'b000, 3'b100, 3'b100);
      check("lk2_no_abort", bus.lock_abort, 1'b0);
    end
    cyc("lk2_abort_gnt", 3'b101, 3'b000, 3'b100, 3'b001);
    check("lk2_abort", bus.lock_abort, 1'b1);
    cyc("lk2_rr1", 3'b101, 3'b000, 3'b100, 3'b100);
    check("lk2_abort_once", bus.lock_abort, 1'b0);
    cyc("lk2_b19", 3'b101, 3'b000, 3'b100, 3'b100);
    cyc("lk2_b20", 3'b101, 3'b000, 3'b100, 3'b100);
    cyc("lk2_idle", 3'b000, 3'b000, 3'b000, 3'b000);

    // Asynchronous reset in the middle of a locked read burst.
    cyc("lk0_b1", 3'b001, 3'b000, 3'b001, 3'b001);
    cyc("lk0_b2", 3'b001, 3'b000, 3'b001, 3'b001);
    @(posedge clk); #1;
    check("lk0_pre_gnt", bus.gnt, 3'b001);
    check("lk0_pre_rvld", bus.rvld, 3'b001);
    #2 rst = 1'b0;
    #1;
    check("arst_gnt", bus.gnt, 3'b000);
    check("arst_rvld", bus.rvld, 3'b000);
    check("arst_mem_we", bus.mem_we, 1'b0);
    check("arst_rdata", bus.rdata, 8'h00);
    @(posedge clk); #3;
    bus.req = 3'b111; bus.lock = 3'b000;
    rst = 1'b1;
    @(negedge clk); #1;
    check("post_rst_first", bus.gnt, 3'b001);
    cyc("post_rst_idle", 3'b000, 3'b000, 3'b000, 3'b000);

    // Randomized traffic: pending requests hold their fields until granted, bar rare withdrawals.
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) begin
        bit pending;
        bit nr;
        pending = bus.req[i] && !seen_gnt[i];
        if ($urandom_range(9) == 0) bus.lock[i] = ~bus.lock[i];
        if (!pending || $urandom_range(15) == 0) begin
          nr = bus.lock[i] ? ($urandom_range(7) != 0) : ($urandom_range(1) == 0);
          drive_port(i, nr, ($urandom_range(3) == 0), AW'($urandom_range(31)), 8'($urandom));
        end
      end
    end
    cyc("end_idle0", 3'b000, 3'b000, 3'b000, 3'b000);
    cyc("end_idle1", 3'b000, 3'b000, 3'b000, 3'b000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
